// File: rtl/teclado_pkg.sv
// rtl/teclado_pkg.sv - shared types, one-hot keypad constants and key-position table
package teclado_pkg;

  typedef enum logic [2:0] {
    ST_SCAN     = 3'd0,
    ST_DEBOUNCE = 3'd1,
    ST_LOAD     = 3'd2,
    ST_STROBE   = 3'd3,
    ST_RELEASE  = 3'd4
  } state_e;

  localparam logic [3:0] L1 = 4'b1000;
  localparam logic [3:0] L2 = 4'b0100;
  localparam logic [3:0] L3 = 4'b0010;
  localparam logic [3:0] L4 = 4'b0001;
  localparam logic [3:0] C1 = 4'b1000;
  localparam logic [3:0] C2 = 4'b0100;
  localparam logic [3:0] C3 = 4'b0010;
  localparam logic [3:0] C4 = 4'b0001;

  localparam logic [3:0] K_STAR  = 4'hE;
  localparam logic [3:0] K_ENTER = 4'hF;

  // Row-major from L1/C1: 1 2 3 A / 4 5 6 B / 7 8 9 C / * 0 Enter D
  localparam logic [63:0] KEY_TABLE = {
    4'h1, 4'h2, 4'h3, 4'hA,
    4'h4, 4'h5, 4'h6, 4'hB,
    4'h7, 4'h8, 4'h9, 4'hC,
    K_STAR, 4'h0, K_ENTER, 4'hD
  };

  function automatic logic onehot4(input logic [3:0] v);
    return (v != 4'b0) && ((v & (v - 4'd1)) == 4'b0);
  endfunction

  function automatic logic [3:0] rotate_col(input logic [3:0] c);
    return {c[0], c[3:1]};
  endfunction

  function automatic logic [1:0] onehot_idx(input logic [3:0] v);
    logic [1:0] idx;
    idx = 2'd0;
    if (v[2]) idx = 2'd1;
    if (v[1]) idx = 2'd2;
    if (v[0]) idx = 2'd3;
    return idx;
  endfunction

  function automatic logic [3:0] key_code(input logic [3:0] l, input logic [3:0] c);
    logic [3:0] pos;
    pos = {onehot_idx(l), onehot_idx(c)};
    return KEY_TABLE[63 - 4 * int'(pos) -: 4];
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// rtl/sync_2ff.sv - two-flop synchronizer for asynchronous level inputs
module sync_2ff #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] meta_q;
  logic [WIDTH-1:0] sync_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/teclado_varredura.sv
// rtl/teclado_varredura.sv - 4x4 keypad column scanner with debounce and one-shot key strobe
module teclado_varredura
  import teclado_pkg::*;
#(
  parameter int SCAN_DIV = 1000,
  parameter int DEB_CNT  = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] lin_in,
  output logic [3:0] col_out,
  output logic [3:0] lin,
  output logic [3:0] col,
  output logic       bot_press
);

  localparam int SW = $clog2(SCAN_DIV);
  localparam int DW = $clog2(DEB_CNT);
  localparam logic [SW-1:0] SCAN_LAST = SW'(SCAN_DIV - 1);
  localparam logic [DW-1:0] DEB_LAST  = DW'(DEB_CNT - 1);

  logic [3:0] lin_s;

  state_e          state_q, state_d;
  logic [SW-1:0]   dwell_q, dwell_d;
  logic [DW-1:0]   deb_q, deb_d;
  logic [3:0]      col_out_q, col_out_d;
  logic [3:0]      cand_lin_q, cand_lin_d;
  logic [3:0]      cand_col_q, cand_col_d;
  logic [3:0]      lin_q, lin_d;
  logic [3:0]      col_q, col_d;
  logic            bot_press_q, bot_press_d;

  sync_2ff #(.WIDTH(4)) u_sync_lin (
    .clk   (clk),
    .rst_n (rst_n),
    .d_i   (lin_in),
    .q_o   (lin_s)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_SCAN;
      dwell_q     <= '0;
      deb_q       <= '0;
      col_out_q   <= C1;
      cand_lin_q  <= '0;
      cand_col_q  <= '0;
      lin_q       <= '0;
      col_q       <= '0;
      bot_press_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      dwell_q     <= dwell_d;
      deb_q       <= deb_d;
      col_out_q   <= col_out_d;
      cand_lin_q  <= cand_lin_d;
      cand_col_q  <= cand_col_d;
      lin_q       <= lin_d;
      col_q       <= col_d;
      bot_press_q <= bot_press_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    dwell_d     = dwell_q;
    deb_d       = deb_q;
    col_out_d   = col_out_q;
    cand_lin_d  = cand_lin_q;
    cand_col_d  = cand_col_q;
    lin_d       = lin_q;
    col_d       = col_q;
    bot_press_d = 1'b0;

    case (state_q)
      ST_SCAN: begin
        if (dwell_q == SCAN_LAST) begin
          dwell_d = '0;
          // Multi-bit rows (ghosting or two keys) are ignored like an idle column.
          if (onehot4(lin_s)) begin
            cand_lin_d = lin_s;
            cand_col_d = col_out_q;
            deb_d      = '0;
            state_d    = ST_DEBOUNCE;
          end else begin
            col_out_d = rotate_col(col_out_q);
          end
        end else begin
          dwell_d = dwell_q + 1'b1;
        end
      end

      ST_DEBOUNCE: begin
        if (lin_s == cand_lin_q) begin
          if (deb_q == DEB_LAST) begin
            deb_d = '0;
            // Outputs update on entry to LOAD so they lead the strobe by a cycle.
            lin_d   = cand_lin_q;
            col_d   = cand_col_q;
            state_d = ST_LOAD;
          end else begin
            deb_d = deb_q + 1'b1;
          end
        end else begin
          deb_d     = '0;
          dwell_d   = '0;
          col_out_d = rotate_col(col_out_q);
          state_d   = ST_SCAN;
        end
      end

      ST_LOAD: begin
        bot_press_d = 1'b1;
        state_d     = ST_STROBE;
      end

      ST_STROBE: begin
        state_d = ST_RELEASE;
      end

      ST_RELEASE: begin
        if (lin_s != 4'b0) begin
          deb_d = '0;
        end else if (deb_q == DEB_LAST) begin
          deb_d     = '0;
          dwell_d   = '0;
          col_out_d = rotate_col(col_out_q);
          state_d   = ST_SCAN;
        end else begin
          deb_d = deb_q + 1'b1;
        end
      end

      default: begin
        state_d = ST_SCAN;
      end
    endcase
  end

  assign col_out   = col_out_q;
  assign lin       = lin_q;
  assign col       = col_q;
  assign bot_press = bot_press_q;

endmodule

// File: tb/tb_teclado_varredura.sv
// tb/tb_teclado_varredura.sv - directed self-checking bench for teclado_varredura
module tb_teclado_varredura;
  import teclado_pkg::*;

  localparam int SCAN_DIV = 4;
  localparam int DEB_CNT  = 3;
  localparam int LAT_MAX  = SCAN_DIV * 4 + DEB_CNT + 5;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] lin_in;
  logic [3:0] col_out;
  logic [3:0] lin;
  logic [3:0] col;
  logic       bot_press;

  logic [3:0] key_lin;
  logic [3:0] key_col;
  logic [3:0] force_val;
  logic       force_en;

  always #5 clk = ~clk;

  // Matrix model: the pressed key's row reads high only while its column is driven.
  assign lin_in = force_en ? force_val : (((col_out & key_col) != 4'b0) ? key_lin : 4'b0);

  teclado_varredura #(
    .SCAN_DIV (SCAN_DIV),
    .DEB_CNT  (DEB_CNT)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .lin_in    (lin_in),
    .col_out   (col_out),
    .lin       (lin),
    .col       (col),
    .bot_press (bot_press)
  );

  int checks   = 0;
  int failures = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  int         pulse_cnt = 0;
  int         wide_cnt  = 0;
  logic       prev_bp   = 1'b0;
  logic [3:0] prev_lin  = 4'b0;
  logic [3:0] prev_col  = 4'b0;
  logic [3:0] cap_lin_pre = 4'b0;
  logic [3:0] cap_col_pre = 4'b0;
  logic [3:0] cap_lin     = 4'b0;
  logic [3:0] cap_col     = 4'b0;

  always @(negedge clk) begin
    if (bot_press === 1'b1) begin
      pulse_cnt++;
      if (prev_bp) wide_cnt++;
      cap_lin_pre = prev_lin;
      cap_col_pre = prev_col;
      cap_lin     = lin;
      cap_col     = col;
    end
    prev_bp  = (bot_press === 1'b1);
    prev_lin = lin;
    prev_col = col;
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  task automatic wait_pulse(input int start, output int lat, output bit got);
    lat = 0;
    got = 1'b0;
    while (lat < 60 && !got) begin
      tick(1);
      lat++;
      if (pulse_cnt != start) got = 1'b1;
    end
  endtask

  task automatic press_key(input logic [3:0] l, input logic [3:0] c, input string tag,
                           input bit do_release, output logic [3:0] code);
    int start;
    int lat;
    bit got;
    start   = pulse_cnt;
    key_lin = l;
    key_col = c;
    wait_pulse(start, lat, got);
    check_eq({tag, "_seen"}, 32'(got), 32'd1);
    check_eq({tag, "_latency_ok"}, 32'(lat <= LAT_MAX), 32'd1);
    check_eq({tag, "_lin_before"}, 32'(cap_lin_pre), 32'(l));
    check_eq({tag, "_col_before"}, 32'(cap_col_pre), 32'(c));
    check_eq({tag, "_lin_at"}, 32'(cap_lin), 32'(l));
    code = key_code(cap_lin, cap_col);
    tick(SCAN_DIV * 12);
    check_eq({tag, "_no_repeat"}, 32'(pulse_cnt), 32'(start + 1));
    if (do_release) begin
      key_lin = 4'b0;
      key_col = 4'b0;
      tick(20);
    end
  endtask

  logic [3:0]  seq_lin [4] = '{L1, L2, L3, L4};
  logic [3:0]  seq_col [4] = '{C2, C3, C1, C3};
  logic [11:0] acc;
  logic [3:0]  code;
  int          start;
  int          lat;
  bit          got;
  int          changes;
  logic [3:0]  last_col;

  initial begin
    rst_n     = 1'b1;
    key_lin   = 4'b0;
    key_col   = 4'b0;
    force_val = 4'b0;
    force_en  = 1'b0;
    #1 rst_n  = 1'b0;
    tick(3);
    check_eq("rst_col_out", 32'(col_out), 32'(C1));
    check_eq("rst_lin", 32'(lin), 32'd0);
    check_eq("rst_col", 32'(col), 32'd0);
    check_eq("rst_bot_press", 32'(bot_press), 32'd0);
    rst_n = 1'b1;

    // Key "2" held, then asynchronous reset while in RELEASE.
    press_key(L1, C2, "key2", 1'b0, code);
    check_eq("key2_col_held", 32'(col_out), 32'(C2));
    rst_n = 1'b0;
    #1;
    check_eq("async_rst_col_out", 32'(col_out), 32'(C1));
    check_eq("async_rst_lin", 32'(lin), 32'd0);
    check_eq("async_rst_col", 32'(col), 32'd0);
    check_eq("async_rst_bp", 32'(bot_press), 32'd0);
    key_lin = 4'b0;
    key_col = 4'b0;
    tick(2);
    rst_n = 1'b1;

    // Bounce on key "6" then stable.
    start   = pulse_cnt;
    key_col = C3;
    for (int i = 0; i < 10; i++) begin
      key_lin = (i % 2 == 0) ? L2 : 4'b0;
      tick(1);
    end
    check_eq("bounce_quiet", 32'(pulse_cnt), 32'(start));
    press_key(L2, C3, "key6", 1'b1, code);
    check_eq("key6_code", 32'(code), 32'h6);

    // Sequence 2, 6, 7, Enter accumulated as the downstream counter would.
    acc = 12'h0;
    for (int k = 0; k < 4; k++) begin
      press_key(seq_lin[k], seq_col[k], $sformatf("seq%0d", k), 1'b1, code);
      if (code <= 4'h9) acc = {acc[7:0], code};
    end
    check_eq("enter_code", 32'(code), 32'(K_ENTER));
    check_eq("seq_acc", 32'(acc), 32'h267);

    // Ghosting pattern must be ignored while scanning continues.
    start     = pulse_cnt;
    changes   = 0;
    last_col  = col_out;
    force_val = 4'b1010;
    force_en  = 1'b1;
    for (int i = 0; i < 50; i++) begin
      tick(1);
      if (col_out != last_col) changes++;
      last_col = col_out;
    end
    force_en = 1'b0;
    check_eq("ghost_no_pulse", 32'(pulse_cnt), 32'(start));
    check_eq("ghost_rotates", 32'(changes >= 11), 32'd1);
    tick(5);

    // Key "1" held across reset: abort at every phase before the strobe.
    key_lin = L1;
    key_col = C1;
    for (int k = 1; k <= 7; k++) begin
      rst_n = 1'b0;
      tick(2);
      start = pulse_cnt;
      rst_n = 1'b1;
      tick(k);
      if (k == 7) check_eq("load_lin_visible", 32'(lin), 32'(L1));
      rst_n = 1'b0;
      #1;
      check_eq($sformatf("abort%0d_lin", k), 32'(lin), 32'd0);
      check_eq($sformatf("abort%0d_col", k), 32'(col), 32'd0);
      check_eq($sformatf("abort%0d_col_out", k), 32'(col_out), 32'(C1));
      tick(1);
      check_eq($sformatf("abort%0d_no_pulse", k), 32'(pulse_cnt), 32'(start));
    end
    tick(1);
    start = pulse_cnt;
    rst_n = 1'b1;
    wait_pulse(start, lat, got);
    check_eq("key1_after_rst_seen", 32'(got), 32'd1);
    check_eq("key1_after_rst_latency", 32'(lat), 32'd8);
    check_eq("key1_after_rst_lin", 32'(cap_lin_pre), 32'(L1));
    key_lin = 4'b0;
    key_col = 4'b0;
    tick(20);

    // One-cycle blip during RELEASE restarts the release count.
    start   = pulse_cnt;
    key_lin = L1;
    key_col = C2;
    wait_pulse(start, lat, got);
    check_eq("glitch_key_seen", 32'(got), 32'd1);
    tick(10);
    key_lin = 4'b0;
    tick(2);
    key_lin = L1;
    tick(1);
    key_lin = 4'b0;
    tick(3);
    check_eq("glitch_still_held", 32'(col_out), 32'(C2));
    tick(2);
    check_eq("glitch_then_rotate", 32'(col_out), 32'(C3));
    check_eq("glitch_one_pulse", 32'(pulse_cnt), 32'(start + 1));
    key_col = 4'b0;
    tick(10);

    check_eq("pulse_single_cycle", 32'(wide_cnt), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/teclado_varredura.md
TECLADO_VARREDURA -- requirements
Module: teclado_varredura

Interface
REQ-001 SHALL have parameter SCAN_DIV, default 1000: clock cycles each column is driven during scanning; legal range 4 or greater.
REQ-002 SHALL have parameter DEB_CNT, default 8: consecutive identical synchronized samples required for press or release; legal range 2 or greater.
REQ-003 SHALL have port clk, input, 1 bit: single clock; all state on rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit: reset, asynchronous, active-low.
REQ-005 SHALL have port lin_in, input, 4 bits: keypad row sense, active-high, asynchronous to clk.
REQ-006 SHALL have port col_out, output, 4 bits: one-hot column drive to keypad.
REQ-007 SHALL have port lin, output, 4 bits: one-hot row of last accepted key; 8=row1, 4=row2, 2=row3, 1=row4.
REQ-008 SHALL have port col, output, 4 bits: one-hot column of last accepted key; 8=col1 (1,4,7,*), 4=col2 (2,5,8,0), 2=col3 (3,6,9,Enter), 1=col4 (A-D).
REQ-009 SHALL have port bot_press, output, 1 bit: single-cycle key-accepted strobe for the keypad accumulator.

Function
REQ-010 SHALL pass lin_in through a 2-FF synchronizer; all decisions use the synchronized value, lin_s.
REQ-011 SHALL implement states SCAN, DEBOUNCE, LOAD, STROBE, RELEASE.
REQ-012 SCAN: a dwell counter counts 0..SCAN_DIV-1 with col_out constant; at terminal count, lin_s one-hot -> latch cand_lin=lin_s, cand_col=col_out, go DEBOUNCE; otherwise rotate col_out 8->4->2->1->8.
REQ-013 SCAN: lin_s with 2 or more bits set (ghosting or multi-press) SHALL be treated as no key.
REQ-014 DEBOUNCE: col_out held; lin_s==cand_lin increments deb counter; mismatch -> SCAN, col_out rotated, counters cleared; DEB_CNT consecutive matches -> LOAD.
REQ-015 LOAD (1 cycle): lin<=cand_lin, col<=cand_col; go STROBE.
REQ-016 STROBE (1 cycle): bot_press=1; lin/col unchanged; go RELEASE.
REQ-017 bot_press SHALL be registered, high exactly one cycle per accepted key; lin/col SHALL be stable from 1 cycle before its rise until the next LOAD.
REQ-018 RELEASE: col_out held; lin_s==0 for DEB_CNT consecutive cycles -> SCAN with col_out rotated; any nonzero lin_s clears the release counter.
REQ-019 A held key SHALL produce exactly one bot_press; auto-repeat is prohibited.
REQ-020 Press latency: bot_press rises no later than SCAN_DIV*4 + DEB_CNT + 5 cycles after a stable press begins.

Reset
REQ-021 rst_n low SHALL immediately force: state=SCAN, col_out=4'b1000, lin=0, col=0, bot_press=0, all counters and synchronizer flops 0.
REQ-022 rst_n asserted mid-DEBOUNCE, LOAD, STROBE or RELEASE SHALL abort with no bot_press; release of rst_n resumes scanning at col1.
REQ-023 Reset deassertion is synchronized externally; the block needs no internal reset synchronizer.

Structure
REQ-024 Shared package teclado_pkg SHALL hold the state encoding, the one-hot row/column constants (L1..L4, C1..C4) and the key-position table used by the bench.
REQ-025 The synchronizer SHALL be the sub-module sync_2ff (width parameter), reusable by other alarm inputs.
REQ-026 Counter widths SHALL be $clog2 of their parameter; no other sub-modules.

Verification (SCAN_DIV=4, DEB_CNT=3)
REQ-027 Press key "2" (drive lin_in=8 while col_out=4, held) -> lin=8, col=4 in the cycle before one bot_press pulse; no further pulse while held.
REQ-028 Bounce: lin_in=4 under col_out=2 toggling every cycle for 10 cycles, then stable -> zero pulses during bounce, then exactly one pulse with lin=4, col=2 (key 6).
REQ-029 Sequence 2, 6, 7, Enter (lin/col 8/4, 4/2, 2/8, 1/2) with full releases fed to teclado_conta -> s=12'h267 after Enter.
REQ-030 Ghost: lin_in=4'b1010 under col_out=8 for 50 cycles -> no bot_press, col_out keeps rotating.
REQ-031 rst_n low during STROBE-1 (DEBOUNCE count 2) -> no pulse, col_out=8, lin=0, col=0 asynchronously.
REQ-032 Release glitch: one-cycle lin_in blip during RELEASE -> release counter restarts; still one total pulse.
